// File: rtl/wingen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wingen_pkg
// Brief    : Shared constants and FSM state type for the 3x3 window generator.
// Revision : 1.0 - initial release
// ============================================================================
package wingen_pkg;

    localparam int PIX_W = 8;
    localparam int K     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage : wingen_pkg
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Brief    : Shift-on-enable delay line; o_dout is the sample written DEPTH
//            enables ago. Storage is deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 28
) (
    input  logic             clk,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_mem[i] <= r_mem[i-1];
            end
            r_mem[0] <= i_din;
        end
    end

    assign o_dout = r_mem[DEPTH-1];

endmodule : line_buffer
`default_nettype wire

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
// Module   : window_gen_3x3
// Brief    : Streaming 3x3 window generator over a raster pixel stream.
//            Optional macro WINGEN_FRAME_CNT_EN adds a 16-bit frame counter.
// Revision : 1.0 - initial release
// ============================================================================
module window_gen_3x3
    import wingen_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [7:0]               in_pixel,
    output logic [7:0]               win00,
    output logic [7:0]               win01,
    output logic [7:0]               win02,
    output logic [7:0]               win10,
    output logic [7:0]               win11,
    output logic [7:0]               win12,
    output logic [7:0]               win20,
    output logic [7:0]               win21,
    output logic [7:0]               win22,
    output logic                     out_valid,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
`ifdef WINGEN_FRAME_CNT_EN
    output logic [15:0]              frame_cnt,
`endif
    output logic                     frame_done
);

    localparam int ROW_W = $clog2(IMG_H);
    localparam int COL_W = $clog2(IMG_W);

    localparam logic [COL_W-1:0] c_col_last = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);
    localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_last_pix;
    logic               w_in_run;
    logic               w_emit;

    logic [PIX_W-1:0]   w_lb1_out;
    logic [PIX_W-1:0]   w_lb2_out;
    logic [PIX_W-1:0]   w_new_col [K];
    logic [PIX_W-1:0]   r_hist    [K][K-1];
    logic [PIX_W-1:0]   r_win     [K][K];

    logic               r_out_valid;
    logic               r_frame_done;
    logic [ROW_W-1:0]   r_out_row;
    logic [COL_W-1:0]   r_out_col;

    assign w_last_col = (r_col == c_col_last);
    assign w_last_row = (r_row == c_row_last);
    assign w_last_pix = w_last_col && w_last_row;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (in_valid) w_state_nxt = FILL;
            FILL: if (in_valid && (r_row == c_row_two) && (r_col == '0)) w_state_nxt = RUN;
            RUN:  if (in_valid && w_last_pix) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // RUN means the two oldest window rows already belong to this frame.
    always_comb begin
        w_in_run = (r_state == RUN);
        w_emit   = in_valid && w_in_run && (r_col >= c_col_two);
    end

    line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .i_en   (in_valid),
        .i_din  (in_pixel),
        .o_dout (w_lb1_out)
    );

    line_buffer #(.WIDTH(PIX_W), .DEPTH(IMG_W)) u_lb2 (
        .clk    (clk),
        .i_en   (in_valid),
        .i_din  (w_lb1_out),
        .o_dout (w_lb2_out)
    );

    always_comb begin
        w_new_col[0] = w_lb2_out;
        w_new_col[1] = w_lb1_out;
        w_new_col[2] = in_pixel;
    end

    // Column history shifts on every accept; the visible window only loads
    // when a complete window exists, so outputs hold between windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 1; c++) begin
                    r_hist[r][c] <= '0;
                end
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K - 2; c++) begin
                    r_hist[r][c] <= r_hist[r][c+1];
                end
                r_hist[r][K-2] <= w_new_col[r];
                if (w_emit) begin
                    for (int c = 0; c < K - 1; c++) begin
                        r_win[r][c] <= r_hist[r][c];
                    end
                    r_win[r][K-1] <= w_new_col[r];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_out_row    <= '0;
            r_out_col    <= '0;
        end else begin
            r_out_valid  <= w_emit;
            r_frame_done <= w_emit && w_last_pix;
            if (w_emit) begin
                r_out_row <= r_row - c_row_two;
                r_out_col <= r_col - c_col_two;
            end
        end
    end

`ifdef WINGEN_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
        end else if (w_emit && w_last_pix) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign win00      = r_win[0][0];
    assign win01      = r_win[0][1];
    assign win02      = r_win[0][2];
    assign win10      = r_win[1][0];
    assign win11      = r_win[1][1];
    assign win12      = r_win[1][2];
    assign win20      = r_win[2][0];
    assign win21      = r_win[2][1];
    assign win22      = r_win[2][2];
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;

endmodule : window_gen_3x3
`default_nettype wire
